fishing_game_ctrl: RTL and testbench

Game sequencer for the fishing scene on the 640x480 VGA display. It owns every position register the pixel renderer draws from: boat/rod x (rpos), line-tip depth (ypos) and the shared fish x (fpos). It also owns per-lane fish presence, catch detection, reeling, score and the game timer. It sits between the debounced buttons and the combinational renderer, and advances only on a frame-rate tick enable.

---
 rtl/fishing_pkg.sv | 22 ++
 rtl/fishing_game_ctrl_catch_detect.sv | 19 +
 rtl/fishing_game_ctrl.sv | 122 ++++++++++++
 tb/tb_fishing_game_ctrl.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/fishing_pkg.sv
// fishing_pkg: shared states, playfield limits and per-lane constants for the fishing game.
package fishing_pkg;
  typedef enum logic [2:0] {S_IDLE, S_CAST, S_HOOKED, S_SCORE, S_GAMEOVER} state_e;
  localparam logic [9:0] X_MIN = 10'd312;
  localparam logic [9:0] X_MAX = 10'd798;
  localparam logic [9:0] Y_SURFACE = 10'd155;
  localparam logic [9:0] Y_BOTTOM = 10'd514;
  localparam logic [9:0] STEP = 10'd2;
  localparam logic [9:0] FISH_STEP = 10'd2;
  localparam logic [9:0] RPOS_INIT = 10'd450;
  localparam logic [10:0] GAME_TICKS = 11'd1800;
  // lane0 is the deepest lane; index 0 sits in the least significant slot
  localparam logic [3:0][9:0] LANE_LO = {10'd197, 10'd285, 10'd372, 10'd460};
  localparam logic [3:0][9:0] LANE_HI = {10'd203, 10'd295, 10'd388, 10'd480};
  localparam logic [3:0][9:0] LANE_W = {10'd10, 10'd20, 10'd40, 10'd60};
  localparam logic [3:0][3:0] LANE_PTS = {4'd8, 4'd4, 4'd2, 4'd1};
  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [3:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {5'b0, b};
    return s[8] ? 8'hff : s[7:0];
  endfunction
endpackage

// File: rtl/fishing_game_ctrl_catch_detect.sv
// catch_detect: flags a line tip touching an active fish, lowest lane wins.
module catch_detect
  import fishing_pkg::*;
(
  input  logic [9:0] rpos_i,
  input  logic [9:0] ypos_i,
  input  logic [9:0] fpos_i,
  input  logic [3:0] fish_active_i,
  output logic       hit_o,
  output logic [1:0] lane_o
);
  logic [3:0] m;
  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign m[i] = fish_active_i[i] && ypos_i >= LANE_LO[i] && ypos_i <= LANE_HI[i] &&
                  fpos_i <= rpos_i && rpos_i <= fpos_i + LANE_W[i];
  end
  assign hit_o = |m;
  assign lane_o = m[0] ? 2'd0 : m[1] ? 2'd1 : m[2] ? 2'd2 : m[3] ? 2'd3 : 2'd0;
endmodule

// File: rtl/fishing_game_ctrl.sv
// fishing_game_ctrl: frame-tick game sequencer owning rod, line, fish, score and timer state.
module fishing_game_ctrl
  import fishing_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick_i,
  input  logic        up_i,
  input  logic        down_i,
  input  logic        left_i,
  input  logic        right_i,
  input  logic        start_i,
  output logic [9:0]  rpos_o,
  output logic [9:0]  ypos_o,
  output logic [9:0]  fpos_o,
  output logic [3:0]  fish_active_o,
  output logic        hooked_o,
  output logic [1:0]  hooked_lane_o,
  output logic [7:0]  score_o,
  output logic [10:0] time_left_o,
  output logic        game_over_o
);
  state_e      state_q;
  logic [9:0]  rpos_q, ypos_q, fpos_q;
  logic [3:0]  fish_q;
  logic        hooked_q, go_q, start_q;
  logic [1:0]  lane_q;
  logic [7:0]  score_q;
  logic [10:0] time_q;
  logic [9:0]  rpos_d, ypos_d, yreel_d, fstep;
  logic        hit, wrap, start_rise;
  logic [1:0]  lane;

  catch_detect u_catch (
    .rpos_i(rpos_q), .ypos_i(ypos_q), .fpos_i(fpos_q), .fish_active_i(fish_q),
    .hit_o(hit), .lane_o(lane)
  );

  assign start_rise = start_i & ~start_q;
  assign fstep = fpos_q - FISH_STEP;
  assign wrap = fstep <= X_MIN;
  // a blocked higher-priority button still swallows the move for this tick
  assign rpos_d = right_i ? (rpos_q + STEP <= X_MAX ? rpos_q + STEP : rpos_q) :
                  left_i  ? (rpos_q >= X_MIN + STEP ? rpos_q - STEP : rpos_q) : rpos_q;
  assign ypos_d = (right_i | left_i) ? ypos_q :
                  up_i   ? (ypos_q >= Y_SURFACE + STEP ? ypos_q - STEP : ypos_q) :
                  down_i ? (ypos_q + STEP <= Y_BOTTOM ? ypos_q + STEP : ypos_q) : ypos_q;
  assign yreel_d = up_i ? (ypos_q >= Y_SURFACE + STEP ? ypos_q - STEP : Y_SURFACE) : ypos_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rpos_q   <= RPOS_INIT;
      ypos_q   <= Y_SURFACE;
      fpos_q   <= X_MAX;
      fish_q   <= 4'b1111;
      hooked_q <= 1'b0;
      lane_q   <= 2'd0;
      score_q  <= 8'd0;
      time_q   <= 11'd0;
      go_q     <= 1'b0;
      start_q  <= 1'b0;
    end else if (tick_i) begin
      start_q <= start_i;
      case (state_q)
        S_IDLE: if (start_rise) begin
          state_q <= S_CAST;
          time_q  <= GAME_TICKS;
          score_q <= 8'd0;
          fish_q  <= 4'b1111;
          fpos_q  <= X_MAX;
          rpos_q  <= RPOS_INIT;
          ypos_q  <= Y_SURFACE;
        end
        S_CAST: if (time_q == 11'd0) begin
          state_q <= S_GAMEOVER;
          go_q    <= 1'b1;
        end else if (hit) begin
          state_q      <= S_HOOKED;
          hooked_q     <= 1'b1;
          lane_q       <= lane;
          fish_q[lane] <= 1'b0;
        end else begin
          time_q <= time_q - 11'd1;
          rpos_q <= rpos_d;
          ypos_q <= ypos_d;
          fpos_q <= wrap ? X_MAX : fstep;
          if (wrap) fish_q <= 4'b1111;
        end
        S_HOOKED: if (time_q == 11'd0) begin
          state_q  <= S_GAMEOVER;
          go_q     <= 1'b1;
          hooked_q <= 1'b0;
        end else begin
          time_q <= time_q - 11'd1;
          ypos_q <= yreel_d;
          if (ypos_q == Y_SURFACE) state_q <= S_SCORE;
        end
        S_SCORE: begin
          score_q  <= sat_add(score_q, LANE_PTS[lane_q]);
          hooked_q <= 1'b0;
          state_q  <= S_CAST;
        end
        S_GAMEOVER: if (start_rise) begin
          state_q <= S_IDLE;
          go_q    <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rpos_o        = rpos_q;
  assign ypos_o        = ypos_q;
  assign fpos_o        = fpos_q;
  assign fish_active_o = fish_q;
  assign hooked_o      = hooked_q;
  assign hooked_lane_o = lane_q;
  assign score_o       = score_q;
  assign time_left_o   = time_q;
  assign game_over_o   = go_q;
endmodule

// File: tb/tb_fishing_game_ctrl.sv
// tb_fishing_game_ctrl: directed game script with hand-computed expectations checked by a tick monitor.
module tb_fishing_game_ctrl;
  logic clk = 1'b0, rst_n = 1'b1, tick = 1'b0;
  logic up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0, start = 1'b0;
  logic [9:0] rpos, ypos, fpos;
  logic [3:0] fish_active;
  logic hooked, game_over, tick_seen = 1'b0;
  logic [1:0] hooked_lane;
  logic [7:0] score;
  logic [10:0] time_left;

  typedef struct {int r, y, f, fa, h, l, s, t, g;} exp_t;
  exp_t q[$];
  int n_chk = 0, n_fail = 0;
  localparam int X = -1;
  localparam logic [4:0] N = 5'd0, R = 5'd1, L = 5'd2, D = 5'd4, U = 5'd8, S = 5'd16;

  fishing_game_ctrl dut (
    .clk(clk), .rst_n(rst_n), .tick_i(tick), .up_i(up), .down_i(down), .left_i(left),
    .right_i(right), .start_i(start), .rpos_o(rpos), .ypos_o(ypos), .fpos_o(fpos),
    .fish_active_o(fish_active), .hooked_o(hooked), .hooked_lane_o(hooked_lane),
    .score_o(score), .time_left_o(time_left), .game_over_o(game_over)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    if (exp >= 0) begin
      n_chk++;
      if (act != exp) begin
        n_fail++;
        $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
    end
  endtask

  task automatic cmp(input exp_t e);
    chk("rpos", int'(rpos), e.r);
    chk("ypos", int'(ypos), e.y);
    chk("fpos", int'(fpos), e.f);
    chk("fish_active", int'(fish_active), e.fa);
    chk("hooked", int'(hooked), e.h);
    chk("hooked_lane", int'(hooked_lane), e.l);
    chk("score", int'(score), e.s);
    chk("time_left", int'(time_left), e.t);
    chk("game_over", int'(game_over), e.g);
  endtask

  always @(posedge clk) tick_seen <= tick;

  // every tick the DUT consumes owes exactly one queued expectation
  always @(negedge clk) if (tick_seen) begin
    if (q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard: tick with no expectation queued at %0t", $time);
    end else cmp(q.pop_front());
  end

  task automatic step(input logic [4:0] b, input int r, y, f, fa, h, l, s, t, g);
    exp_t e;
    @(negedge clk);
    {start, up, down, left, right} = b;
    tick = 1'b1;
    e = '{r, y, f, fa, h, l, s, t, g};
    q.push_back(e);
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic run(input logic [4:0] b, input int n);
    repeat (n) step(b, X, X, X, X, X, X, X, X, X);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t rst_e;
    rst_e = '{450, 155, 798, 15, 0, 0, 0, 0, 0};
    #2 rst_n = 1'b0;
    #1 cmp(rst_e);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    // start held three ticks: only the first edge launches the game
    step(S, 450, 155, 798, 15, 0, 0, 0, 1800, 0);
    step(S, 450, 155, 796, X, X, X, X, 1799, X);
    step(S, 450, 155, 794, X, X, X, X, 1798, 0);
    run(R, 172);
    step(R, 796, 155, 448, X, X, X, X, 1625, X);
    step(R, 798, 155, 446, X, X, X, X, 1624, X);
    step(R, 798, 155, 444, X, X, X, X, 1623, X);
    step(U, 798, 155, 442, X, X, X, X, 1622, X);
    run(L, 242);
    step(L, 312, 155, 442, 15, X, X, X, 1379, X);
    step(L, 312, 155, 440, X, X, X, X, 1378, X);
    run(D, 178);
    step(D, 312, 513, 568, X, X, X, X, 1199, X);
    step(D, 312, 513, 566, 15, 0, X, 0, 1198, 0);
    run(U, 21);
    step(U, 312, 469, 522, 15, 0, X, 0, 1176, X);
    run(R, 52);
    step(R, 418, 469, 416, 15, 0, X, X, 1123, X);
    // lane0 catch, then reel with every other button pressed too
    step(R, 418, 469, 416, 14, 1, 0, 0, 1123, 0);
    step(U | D | L | R | S, 418, 467, 416, 14, 1, 0, 0, 1122, 0);
    run(U, 155);
    step(U, 418, 155, 416, 14, 1, 0, 0, 966, 0);
    step(N, 418, 155, 416, 14, 1, 0, 0, 965, 0);
    step(N, 418, 155, 416, 14, 0, X, 1, 965, 0);
    step(N, 418, 155, 414, 14, 0, X, 1, 964, 0);
    run(D, 65);
    step(D, 418, 287, 768, 15, 0, X, 1, 898, 0);
    run(N, 174);
    step(N, 418, 287, 418, 15, 0, X, 1, 723, 0);
    step(N, 418, 287, 418, 11, 1, 2, 1, 723, 0);
    run(U, 65);
    step(U, 418, 155, 418, 11, 1, 2, 1, 657, 0);
    step(N, 418, 155, 418, 11, 1, 2, 1, 656, 0);
    step(N, 418, 155, 418, 11, 0, X, 5, 656, 0);
    run(N, 51);
    step(N, 418, 155, 314, 11, 0, X, 5, 604, 0);
    step(N, 418, 155, 798, 15, 0, X, 5, 603, 0);
    run(D, 20);
    step(D, 418, 197, 756, 15, 0, X, 5, 582, 0);
    run(N, 168);
    step(N, 418, 197, 418, 15, 0, X, 5, 413, 0);
    step(S, 418, 197, 418, 7, 1, 3, 5, 413, 0);
    run(N, 412);
    step(N, 418, 197, 418, 7, 1, 3, 5, 0, 0);
    step(N, 418, 197, 418, 7, 0, X, 5, 0, 1);
    step(N, 418, 197, 418, 7, 0, X, 5, 0, 1);
    step(S, 418, 197, 418, X, 0, X, 5, 0, 0);
    step(S, 418, 197, 418, X, 0, X, 5, 0, 0);
    step(N, 418, 197, 418, X, 0, X, 5, 0, 0);
    step(S, 450, 155, 798, 15, 0, X, 0, 1800, 0);
    // second game: start held throughout, timer expires in CAST
    run(S, 1798);
    step(S, 450, 155, 602, X, 0, X, 0, 1, 0);
    step(S, 450, 155, 600, X, 0, X, 0, 0, 0);
    step(S, 450, 155, 600, X, 0, X, 0, 0, 1);
    step(S, 450, 155, 600, X, 0, X, 0, 0, 1);
    step(N, 450, 155, 600, X, 0, X, 0, 0, 1);
    step(S, 450, 155, 600, X, 0, X, 0, 0, 0);
    step(N, 450, 155, 600, X, 0, X, 0, 0, 0);
    step(S, 450, 155, 798, 15, 0, X, 0, 1800, 0);
    run(R, 10);
    #2 rst_n = 1'b0;
    #1 cmp(rst_e);
    @(negedge clk);
    rst_n = 1'b1;
    step(N, 450, 155, 798, 15, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
